// File: rtl/pc_unit.sv
// Program-counter stage: next-PC selection, kernel vectoring on reset,
// interrupt and illegal instruction, and $k0 return-address handoff.
module pc_unit #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] jtarget,
  input  logic [31:0] jr_addr,
  input  logic        illop,
  input  logic        irq,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        squash,
  output logic        k0_we,
  output logic [31:0] k0_wdata,
  output logic        irq_ack,
  output logic        in_kernel
);

  localparam logic [1:0] SRC_SEQ = 2'd0;
  localparam logic [1:0] SRC_BR  = 2'd1;
  localparam logic [1:0] SRC_J   = 2'd2;
  localparam logic [1:0] SRC_JR  = 2'd3;

  logic [31:0] pc_q, pc_d;
  logic        irq_pending_q, irq_pending_d;
  logic        irq_d_q, irq_d_d;

  logic        kern;
  logic        take_exc;
  logic        take_irq;
  logic        irq_rise;
  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] flow_pc;
  logic [31:0] next_pc;

  assign kern     = pc_q[31];
  assign pc_plus4 = pc_q + 32'd4;
  assign take_exc = illop & ~kern;
  assign take_irq = irq_pending_q & ~kern & ~illop;
  assign irq_rise = irq & ~irq_d_q;
  assign br_off   = {{14{imm16[15]}}, imm16, 2'b00};
  assign br_tgt   = pc_plus4 + br_off;

  always_comb begin
    flow_pc = pc_plus4;
    unique case (pc_src)
      SRC_SEQ: flow_pc = pc_plus4;
      SRC_BR: begin
        if (branch_taken) flow_pc = {kern, br_tgt[30:0]};
      end
      SRC_J:   flow_pc = {pc_plus4[31:28], jtarget, 2'b00};
      // jr may drop privilege but never raise it
      SRC_JR:  flow_pc = {kern & jr_addr[31], jr_addr[30:0]};
      default: flow_pc = pc_plus4;
    endcase
  end

  always_comb begin
    next_pc  = flow_pc;
    squash   = 1'b0;
    k0_we    = 1'b0;
    k0_wdata = pc_plus4;
    irq_ack  = 1'b0;
    unique case (1'b1)
      take_exc: begin
        next_pc  = EXC_VEC;
        squash   = en;
        k0_we    = en;
        k0_wdata = pc_plus4;
      end
      take_irq: begin
        next_pc  = IRQ_VEC;
        squash   = en;
        k0_we    = en;
        k0_wdata = pc_q;
        irq_ack  = en;
      end
      default: next_pc = flow_pc;
    endcase
  end

  always_comb begin
    pc_d          = pc_q;
    irq_d_d       = irq;
    irq_pending_d = irq_rise | (irq_pending_q & ~irq_ack);
    if (en) pc_d = {next_pc[31:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q          <= RESET_VEC;
      irq_pending_q <= 1'b0;
      irq_d_q       <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      irq_pending_q <= irq_pending_d;
      irq_d_q       <= irq_d_d;
    end
  end

  assign pc        = pc_q;
  assign in_kernel = pc_q[31];

endmodule
